// File: rtl/sd_pkg.sv
// Shared definitions for the packed signed-digit store: digit codes, nibble width
// and sequencer state encodings used by both the read and write sides.
package sd_pkg;

    typedef logic [1:0] sd_digit_t;

    localparam sd_digit_t SD_ZERO = 2'b00;
    localparam sd_digit_t SD_POS  = 2'b10;
    localparam sd_digit_t SD_NEG  = 2'b01;
    localparam sd_digit_t SD_BAD  = 2'b11;

    localparam int NIB_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    function automatic logic sd_is_bad(input sd_digit_t d);
        return d == SD_BAD;
    endfunction

endpackage

// File: rtl/sd_word_reader_if.sv
// RAM read port plus digit-pair stream between the word reader (master) and its
// surroundings (slave: the RAM and the online multiplier).
interface sd_word_reader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    import sd_pkg::*;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              out_valid;
    logic              out_ready;
    sd_digit_t         x_out;
    sd_digit_t         y_out;
    logic              out_last;

    modport master (
        output ram_addr, ram_re, out_valid, x_out, y_out, out_last,
        input  ram_rdata, out_ready
    );

    modport slave (
        input  ram_addr, ram_re, out_valid, x_out, y_out, out_last,
        output ram_rdata, out_ready
    );

endinterface

// File: rtl/sd_nibble_unpack.sv
// Selects one 4-bit nibble from a packed word and splits it into the x/y
// signed-digit pair {x_plus,x_minus,y_plus,y_minus}; flags the illegal 2'b11 code.
module sd_nibble_unpack
    import sd_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    output sd_digit_t         o_x,
    output sd_digit_t         o_y,
    output logic              o_bad
);

    logic [NIB_W-1:0] w_nib;

    // Nibble k starts at bit 4k, so the index shifted left by two is the bit offset.
    assign w_nib = i_word[{i_idx, 2'b00} +: NIB_W];
    assign o_x   = w_nib[3:2];
    assign o_y   = w_nib[1:0];
    assign o_bad = sd_is_bad(o_x) || sd_is_bad(o_y);

endmodule

// File: rtl/sd_word_reader.sv
// Read side of the packed signed-digit store: bursts words out of the RAM and
// streams four x/y digit pairs per word to the online multiplier.
module sd_word_reader
    import sd_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int DIG_PER_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_num_words,
    sd_word_reader_if.master  bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sd_err
);

    localparam int IDX_W = $clog2(DIG_PER_W);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_nib_idx;
    logic              r_sd_err;

    sd_digit_t w_x;
    sd_digit_t w_y;
    logic      w_bad;
    logic      w_accept;
    logic      w_last_nib;
    logic      w_last_word;

    sd_nibble_unpack #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_unpack (
        .i_word (r_word),
        .i_idx  (r_nib_idx),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_bad  (w_bad)
    );

    assign w_accept    = (r_state == ST_EMIT) && bus.out_ready;
    assign w_last_nib  = (r_nib_idx == IDX_W'(DIG_PER_W - 1));
    assign w_last_word = (r_word_cnt == ADDR_W'(1));

    // NOTE: every register below is assigned with <= so that all of them update
    // from the same pre-edge values; a blocking assignment here would let later
    // statements see half-updated state and change the synthesized logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_word     <= '0;
            r_nib_idx  <= '0;
            r_sd_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr     <= i_base_addr;
                        r_word_cnt <= i_num_words;
                        r_sd_err   <= 1'b0;
                        r_state    <= (i_num_words == '0) ? ST_FIN : ST_READ;
                    end
                end
                ST_READ:  r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_word    <= bus.ram_rdata;
                    r_nib_idx <= '0;
                    r_state   <= ST_EMIT;
                end
                ST_EMIT: begin
                    // Sticky: re-setting on a held nibble has no further effect.
                    if (w_bad) r_sd_err <= 1'b1;
                    if (w_accept) begin
                        if (!w_last_nib) begin
                            r_nib_idx <= r_nib_idx + 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt - 1'b1;
                            r_addr     <= r_addr + 1'b1;
                            r_state    <= w_last_word ? ST_FIN : ST_READ;
                        end
                    end
                end
                ST_FIN:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_re    = (r_state == ST_READ);
    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.x_out     = w_x;
    assign bus.y_out     = w_y;
    assign bus.out_last  = bus.out_valid && w_last_word && w_last_nib;

    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_FIN);
    assign o_sd_err = r_sd_err;

endmodule

// File: tb/tb_sd_word_reader.sv
// Directed bench for sd_word_reader: a bench-side RAM, a queue model of the
// expected digit-pair stream, a per-cycle monitor and hand-computed pins.
module tb_sd_word_reader;
    import sd_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        logic       last;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [ADDR_W-1:0] i_num_words = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_sd_err;

    sd_word_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sd_word_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DIG_PER_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_words (i_num_words),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sd_err    (o_sd_err)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [128];
    always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state and per-burst observations
    pair_t             exp_q[$];
    pair_t             got_q[$];
    int                accept_cycs[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic              exp_err = 1'b0;
    int                first_valid_cyc = -1;
    int                busy_cycles = 0;
    int                done_cnt = 0;
    int                done_cyc = -1;
    int                start_cyc = 0;
    logic              mon_en = 1'b0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [1:0] prev_x, prev_y;
    logic       prev_last;
    pair_t      m_e, m_g;

    // Expected stream from the stored words: word order, then nibble 0..3 within each.
    task automatic load_expected(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] num);
        for (int w = 0; w < int'(num); w++) begin
            logic [DATA_W-1:0] word;
            word = mem[(int'(base) + w) % 128];
            for (int k = 0; k < 4; k++) begin
                pair_t p;
                logic [3:0] nib;
                nib    = 4'((word >> (4 * k)) & 16'hF);
                p.x    = nib[3:2];
                p.y    = nib[1:0];
                p.last = (w == int'(num) - 1) && (k == 3);
                exp_q.push_back(p);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else if (mon_en) begin
            check("sd_err", o_sd_err, exp_err);
            if (o_busy) busy_cycles++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.ram_re) addr_q.push_back(bus.ram_addr);
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_valid && !prev_ready) begin
                    check("hold_x", bus.x_out, prev_x);
                    check("hold_y", bus.y_out, prev_y);
                    check("hold_last", bus.out_last, prev_last);
                end
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", bus.out_valid, 1'b0);
                end else begin
                    m_e = exp_q[0];
                    check("x_out", bus.x_out, m_e.x);
                    check("y_out", bus.y_out, m_e.y);
                    check("out_last", bus.out_last, m_e.last);
                    if (m_e.x == SD_BAD || m_e.y == SD_BAD) exp_err = 1'b1;
                    if (bus.out_ready) begin
                        m_g.x    = bus.x_out;
                        m_g.y    = bus.y_out;
                        m_g.last = bus.out_last;
                        got_q.push_back(m_g);
                        accept_cycs.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("last_without_valid", bus.out_last, 1'b0);
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_x     = bus.x_out;
            prev_y     = bus.y_out;
            prev_last  = bus.out_last;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 in the first cycle after the start edge.
    task automatic start_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] num);
        got_q.delete();
        accept_cycs.delete();
        addr_q.delete();
        first_valid_cyc = -1;
        busy_cycles     = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        load_expected(base, num);
        i_base_addr = base;
        i_num_words = num;
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        exp_err   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check("model_drained", exp_q.size(), 0);
    endtask

    logic [1:0] t1_x [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] t1_y [4] = '{2'b01, 2'b10, 2'b00, 2'b00};

    task automatic check_t1_pairs(input string tag);
        check({tag, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check($sformatf("%s_x%0d", tag, i), got_q[i].x, t1_x[i]);
            check($sformatf("%s_y%0d", tag, i), got_q[i].y, t1_y[i]);
            check($sformatf("%s_last%0d", tag, i), got_q[i].last, (i == 3));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[5]   = 16'h8421;
        mem[10]  = 16'h00F0;
        mem[127] = 16'h9A26;
        mem[0]   = 16'h4182;
        mem[20]  = 16'h1111;
        mem[21]  = 16'h2222;
        mem[22]  = 16'h4444;
        bus.out_ready = 1'b1;

        // Reset values
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_re", bus.ram_re, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_x_out", bus.x_out, 0);
        check("rst_y_out", bus.y_out, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sd_err", o_sd_err, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 1: single word, full throughput
        start_burst(7'd5, 7'd1);
        check("t1_ram_re", bus.ram_re, 1);
        check("t1_ram_addr", bus.ram_addr, 5);
        check("t1_busy", o_busy, 1);
        wait_done(50);
        check_t1_pairs("t1");
        check("t1_first_valid", first_valid_cyc, start_cyc + 2);
        check("t1_done_cnt", done_cnt, 1);
        if (accept_cycs.size() == 4) check("t1_done_after_last", done_cyc, accept_cycs[3] + 1);
        else check("t1_accepts", accept_cycs.size(), 4);
        check("t1_busy_cycles", busy_cycles, 7);

        // 2: empty burst
        start_burst(7'd9, 7'd0);
        check("t2_done", o_done, 1);
        check("t2_busy", o_busy, 1);
        check("t2_ram_re", bus.ram_re, 0);
        @(posedge clk);
        #1;
        check("t2_done_drop", o_done, 0);
        check("t2_busy_drop", o_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_done_cnt", done_cnt, 1);
        check("t2_busy_cycles", busy_cycles, 1);
        check("t2_no_pairs", got_q.size(), 0);

        // 3: address wrap 127 -> 0 over two words
        start_burst(7'd127, 7'd2);
        wait_done(60);
        check("t3_addr_count", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check("t3_addr0", addr_q[0], 127);
            check("t3_addr1", addr_q[1], 0);
        end
        check("t3_pairs", got_q.size(), 8);
        if (got_q.size() == 8) begin
            check("t3_p0_x", got_q[0].x, 2'b01);
            check("t3_p0_y", got_q[0].y, 2'b10);
            check("t3_p4_x", got_q[4].x, 2'b00);
            check("t3_p4_y", got_q[4].y, 2'b10);
            check("t3_last3", got_q[3].last, 0);
            check("t3_last7", got_q[7].last, 1);
            check("t3_gap_in_word", accept_cycs[1] - accept_cycs[0], 1);
            check("t3_gap_between_words", accept_cycs[4] - accept_cycs[3], 3);
        end

        // 4: random back-pressure, same word as test 1
        start_burst(7'd5, 7'd1);
        begin
            int n = 0;
            while (done_cnt == 0 && n < 400) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                n++;
            end
            if (done_cnt == 0) check("t4_done_timeout", 32'd0, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_t1_pairs("t4");
        check("t4_done_cnt", done_cnt, 1);

        // 5: illegal digit code sets the sticky error; next start clears it
        start_burst(7'd10, 7'd1);
        wait_done(50);
        check("t5_p1_x", (got_q.size() > 1) ? got_q[1].x : 2'b00, 2'b11);
        check("t5_p1_y", (got_q.size() > 1) ? got_q[1].y : 2'b00, 2'b11);
        check("t5_err_after_done", o_sd_err, 1);
        start_burst(7'd5, 7'd1);
        check("t5_err_cleared", o_sd_err, 0);
        wait_done(50);
        check("t5_err_stays_clear", o_sd_err, 0);

        // 6: reset in the middle of a three-word burst
        start_burst(7'd20, 7'd3);
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 50) begin
                @(posedge clk);
                n++;
            end
            #1;
            check("t6_first_pair", got_q.size(), 1);
        end
        check("t6_second_shown", bus.out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_valid_drop", bus.out_valid, 0);
        check("t6_busy_drop", o_busy, 0);
        check("t6_no_done", o_done, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done_later", done_cnt, 0);
        start_burst(7'd5, 7'd1);
        wait_done(50);
        check_t1_pairs("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
